// File: rtl/proc_pkg.sv
// proc_pkg: shared opcode, instruction-field and sequencer-state definitions
package proc_pkg;
  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_MVT  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_HALT = 3'b111;
  localparam int OPC_HI  = 15;
  localparam int OPC_LO  = 13;
  localparam int IMM_BIT = 12;
  localparam int RX_HI   = 11;
  localparam int RX_LO   = 9;
  localparam int RY_HI   = 8;
  localparam int RY_LO   = 6;
  localparam int IMM9_HI = 8;
  localparam int IMM9_LO = 0;
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HALT, S_ERROR} seq_state_t;
  function automatic logic is_halt(input logic [15:0] w);
    return w[OPC_HI:OPC_LO] == OP_HALT;
  endfunction
endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: program-load, start and Run/Done handshake bundle
interface instr_sequencer_if #(parameter int AW = 4);
  logic          start;
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [15:0]   prog_data;
  logic          Done;
  logic [15:0]   instruction;
  logic          Run;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;
  logic          timeout_err;
  logic [15:0]   instr_count;
  modport master (
    input  start, prog_we, prog_addr, prog_data, Done,
    output instruction, Run, pc, busy, halted, timeout_err, instr_count
  );
  modport slave (
    output start, prog_we, prog_addr, prog_data, Done,
    input  instruction, Run, pc, busy, halted, timeout_err, instr_count
  );
endinterface

// File: rtl/instr_ram.sv
// instr_ram: program memory with synchronous write and asynchronous read
module instr_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);
  logic [15:0] mem [DEPTH];
  // contents are deliberately not reset so a program survives Rest
  always_ff @(posedge clock)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: feeds program words to the control unit over Run/Done
module instr_sequencer
  import proc_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 15
) (
  input logic clock,
  input logic Rest,
  instr_sequencer_if.master bus
);
  localparam int WW = $clog2(TIMEOUT + 1);
  seq_state_t    state, state_n;
  logic [AW-1:0] pc, pc_n, raddr;
  logic [15:0]   ins, ins_n, cnt, cnt_n, rdata;
  logic [WW-1:0] wd, wd_n;
  logic          run, run_n, hlt, hlt_n, terr, terr_n;
  // read port looks ahead to pc+1 while executing, otherwise at the entry word
  assign raddr = (state == S_EXEC) ? pc + AW'(1) : '0;
  instr_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clock(clock),
    .we(bus.prog_we && state != S_EXEC),
    .waddr(bus.prog_addr),
    .wdata(bus.prog_data),
    .raddr(raddr),
    .rdata(rdata)
  );
  // next-state and registered-output logic
  always_comb begin
    state_n = state;
    pc_n    = pc;
    ins_n   = ins;
    cnt_n   = cnt;
    wd_n    = wd;
    run_n   = run;
    hlt_n   = hlt;
    terr_n  = terr;
    case (state)
      S_EXEC: begin
        if (bus.Done) begin
          cnt_n = cnt + 16'd1;
          wd_n  = '0;
          if (pc == AW'(DEPTH - 1) || is_halt(rdata)) begin
            state_n = S_HALT;
            run_n   = 1'b0;
            hlt_n   = 1'b1;
          end
          if (pc != AW'(DEPTH - 1)) begin
            pc_n  = pc + AW'(1);
            ins_n = rdata;
          end
        end else begin
          wd_n = wd + WW'(1);
          if (wd == WW'(TIMEOUT - 1)) begin
            state_n = S_ERROR;
            run_n   = 1'b0;
            terr_n  = 1'b1;
          end
        end
      end
      default: begin
        run_n = 1'b0;
        if (bus.start) begin
          ins_n   = rdata;
          pc_n    = '0;
          wd_n    = '0;
          cnt_n   = '0;
          terr_n  = 1'b0;
          hlt_n   = is_halt(rdata);
          run_n   = !is_halt(rdata);
          state_n = is_halt(rdata) ? S_HALT : S_EXEC;
        end
      end
    endcase
  end
  // state register with synchronous reset taking priority
  always_ff @(posedge clock) begin
    if (Rest) begin
      state <= S_IDLE;
      pc    <= '0;
      ins   <= '0;
      cnt   <= '0;
      wd    <= '0;
      run   <= 1'b0;
      hlt   <= 1'b0;
      terr  <= 1'b0;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      ins   <= ins_n;
      cnt   <= cnt_n;
      wd    <= wd_n;
      run   <= run_n;
      hlt   <= hlt_n;
      terr  <= terr_n;
    end
  end
  assign bus.instruction = ins;
  assign bus.Run         = run;
  assign bus.pc          = pc;
  assign bus.busy        = state == S_EXEC;
  assign bus.halted      = hlt;
  assign bus.timeout_err = terr;
  assign bus.instr_count = cnt;
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed self-checking bench for instr_sequencer
module tb_instr_sequencer;
  logic clock = 1'b0;
  logic Rest  = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cnt;
  instr_sequencer_if #(.AW(4)) b();
  instr_sequencer #(.DEPTH(16), .AW(4), .TIMEOUT(15)) dut (
    .clock(clock),
    .Rest(Rest),
    .bus(b)
  );
  always #5 clock = ~clock;
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic load(input logic [3:0] a, input logic [15:0] d);
    b.prog_we = 1'b1;
    b.prog_addr = a;
    b.prog_data = d;
    tick();
    b.prog_we = 1'b0;
  endtask
  task automatic go();
    b.start = 1'b1;
    tick();
    b.start = 1'b0;
  endtask
  task automatic done_after(input int n);
    logic [15:0] w;
    w = b.instruction;
    for (int i = 0; i < n; i++) begin
      chk("run_hold", b.Run, 1);
      chk("ins_hold", b.instruction, w);
      tick();
    end
    b.Done = 1'b1;
    tick();
    b.Done = 1'b0;
  endtask
  initial begin
    b.start = 0; b.prog_we = 0; b.prog_addr = 0; b.prog_data = 0; b.Done = 0;
    tick(); tick();
    Rest = 1'b0;
    chk("rst_run", b.Run, 0);
    chk("rst_ins", b.instruction, 16'h0000);
    chk("rst_pc", b.pc, 0);
    chk("rst_busy", b.busy, 0);
    chk("rst_flags", {b.halted, b.timeout_err}, 0);
    chk("rst_cnt", b.instr_count, 0);
    load(0, 16'h1005); load(1, 16'h5003); load(2, 16'hE000);
    go();
    chk("b_ins0", b.instruction, 16'h1005);
    chk("b_run0", b.Run, 1);
    chk("b_busy0", b.busy, 1);
    chk("b_pc0", b.pc, 0);
    done_after(2);
    chk("b_ins1", b.instruction, 16'h5003);
    chk("b_run1", b.Run, 1);
    chk("b_pc1", b.pc, 1);
    done_after(4);
    chk("b_ins2", b.instruction, 16'hE000);
    chk("b_run2", b.Run, 0);
    chk("b_halt", b.halted, 1);
    chk("b_cnt", b.instr_count, 2);
    chk("b_pc2", b.pc, 2);
    chk("b_busy2", b.busy, 0);
    b.Done = 1'b1; tick(); b.Done = 1'b0;
    chk("done_ignored", b.instr_count, 2);
    load(0, 16'h5003);
    go();
    cnt = 0;
    for (int i = 0; i < 40 && b.Run; i++) begin cnt++; tick(); end
    chk("wd_cycles", cnt, 15);
    chk("wd_run", b.Run, 0);
    chk("wd_err", b.timeout_err, 1);
    chk("wd_busy", b.busy, 0);
    go();
    chk("wd_clr", b.timeout_err, 0);
    chk("wd_pc", b.pc, 0);
    chk("wd_run2", b.Run, 1);
    done_after(1);
    chk("wd_pc1", b.pc, 1);
    done_after(1);
    chk("wd_halt", b.halted, 1);
    chk("wd_cnt", b.instr_count, 2);
    go();
    repeat (14) tick();
    b.Done = 1'b1; tick(); b.Done = 1'b0;
    chk("col_pc", b.pc, 1);
    chk("col_run", b.Run, 1);
    chk("col_err", b.timeout_err, 0);
    done_after(0);
    chk("col_halt", b.halted, 1);
    for (int i = 0; i < 16; i++) load(4'(i), 16'h1001);
    go();
    for (int i = 0; i < 15; i++) done_after(2);
    chk("eom_pc15", b.pc, 15);
    chk("eom_run15", b.Run, 1);
    done_after(2);
    chk("eom_cnt", b.instr_count, 16);
    chk("eom_halt", b.halted, 1);
    chk("eom_pc", b.pc, 15);
    chk("eom_run", b.Run, 0);
    load(0, 16'h1005); load(1, 16'h5003); load(2, 16'hE000);
    go();
    b.prog_we = 1'b1; b.prog_addr = 1; b.prog_data = 16'hE000; b.start = 1'b1;
    tick();
    b.prog_we = 1'b0; b.start = 1'b0;
    chk("blk_pc", b.pc, 0);
    chk("blk_ins", b.instruction, 16'h1005);
    chk("blk_run", b.Run, 1);
    done_after(0);
    chk("blk_ram1", b.instruction, 16'h5003);
    chk("blk_pc1", b.pc, 1);
    Rest = 1'b1; tick(); Rest = 1'b0;
    chk("mr_run", b.Run, 0);
    chk("mr_ins", b.instruction, 16'h0000);
    chk("mr_pc", b.pc, 0);
    chk("mr_cnt", b.instr_count, 0);
    chk("mr_busy", b.busy, 0);
    go();
    chk("rr_ins0", b.instruction, 16'h1005);
    done_after(0);
    chk("rr_ins1", b.instruction, 16'h5003);
    done_after(0);
    chk("rr_ins2", b.instruction, 16'hE000);
    chk("rr_halt", b.halted, 1);
    b.prog_we = 1'b1; b.prog_addr = 0; b.prog_data = 16'hE000; b.start = 1'b1;
    tick();
    b.prog_we = 1'b0; b.start = 1'b0;
    chk("ws_old", b.instruction, 16'h1005);
    chk("ws_run", b.Run, 1);
    chk("ws_halt_clr", b.halted, 0);
    done_after(0);
    done_after(0);
    go();
    chk("hs_ins", b.instruction, 16'hE000);
    chk("hs_run", b.Run, 0);
    chk("hs_halt", b.halted, 1);
    chk("hs_cnt", b.instr_count, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Initiator side of the control unit's Run/Done instruction handshake.
- Holds a small program RAM loaded over a write port, and presents one 16-bit instruction at a time on `instruction`, keeping it stable.
- Holds `Run` high while the control unit executes, and advances to the next word on `Done`.
- Stops on a HALT opcode, at end of memory, or on a watchdog timeout.

Parameters:
- DEPTH, 16, program RAM words; must be a power of 2.
- AW, 4, address width; equals log2(DEPTH).
- TIMEOUT, 15, maximum EXEC cycles without `Done` before error; must be at least 1.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- Rest  in  1  synchronous, active-high reset.
- start  in  1  begin executing from address 0; honoured only in IDLE, HALT or ERROR.
- prog_we  in  1  program RAM write enable; honoured only when not busy.
- prog_addr  in  AW  RAM write address.
- prog_data  in  16  RAM write data.
- Done  in  1  instruction-complete pulse from the control unit.
- instruction  out  16  current instruction word (registered).
- Run  out  1  execute enable to the control unit (registered).
- pc  out  AW  address of the word currently on `instruction`.
- busy  out  1  high in EXEC.
- halted  out  1  sticky; set on entering HALT.
- timeout_err  out  1  sticky; set on entering ERROR.
- instr_count  out  16  number of completed instructions; wraps at 16'hFFFF.

Behaviour:
- **Reset.** `Rest` high at an edge forces: state=IDLE, pc=0, instruction=16'h0000, Run=0, busy=0, halted=0, timeout_err=0, instr_count=0, watchdog=0.
  - RAM contents are not reset.
  - Reset mid-EXEC drops `Run` on the next edge.
  - `Rest` has priority over every other input.
- **Instruction fields.** opcode = [15:13]; opcode 3'b111 = HALT. No other field is decoded here.
- **States:** IDLE, EXEC, HALT, ERROR.
- **IDLE**
  - Run=0.
  - start=1 → instruction<=RAM[0], pc<=0, watchdog<=0, instr_count<=0.
  - If RAM[0] opcode is HALT → HALT with Run=0; otherwise → EXEC with Run<=1.
  - Start latency: 1 cycle.
- **EXEC**
  - Run=1 and instruction is held constant until `Done` is sampled high.
  - Done=0 → watchdog++. When watchdog reaches TIMEOUT → ERROR, Run<=0, timeout_err<=1.
  - Done=1 → instr_count++, watchdog<=0, then:
    - if pc==DEPTH-1 → HALT, Run<=0, halted<=1 (end of memory, no wrap);
    - else pc<=pc+1 and instruction<=RAM[pc+1] on the same edge (zero bubble, Run stays 1);
    - if RAM[pc+1] opcode is HALT → HALT, Run<=0, halted<=1; the HALT word remains on `instruction`.
  - Done and watchdog expiry in the same cycle: Done wins.
- **HALT / ERROR**
  - Run=0; outputs hold their values.
  - start=1 clears halted and timeout_err and behaves exactly as start from IDLE.
- **Done outside EXEC** is ignored.
- **RAM**
  - Synchronous write, asynchronous read.
  - prog_we while busy is ignored: no write occurs.
  - prog_we and start in the same cycle (not busy): the write commits, and the fetch of RAM[0] reads the pre-write contents.
- **start while busy** is ignored.
- **Timing rationale.** The instruction changes on the edge where Done=1 is sampled. That is the edge on which the control unit performs its T0 step, so the new word is stable before its T1 decode.

Decomposition:
- Shared package `proc_pkg`:
  - opcode constants OP_MV=3'b000, OP_MVT=3'b001, OP_ADD=3'b010, OP_SUB=3'b011, OP_HALT=3'b111;
  - field bit positions (opcode, imm flag, rx, ry, imm9);
  - sequencer state encoding.
- One sub-module `instr_ram` (DEPTH x 16, write port plus asynchronous read port). Everything else stays in `instr_sequencer`.

Test Plan:
- **Basic program.** Load 0x1005 (mv r0,#5), 0x5003 (add r0,#3), 0xE000 (halt); pulse start. Responder model raises Done 2 cycles after first seeing Run for mv, 4 for add.
  - Expect: instruction sequence 0x1005 → 0x5003 → 0xE000; Run high continuously until the HALT word appears, then 0; halted=1; instr_count=2; pc=2.
- **Watchdog.** Load 0x5003; start; responder never asserts Done.
  - Expect: exactly TIMEOUT=15 EXEC cycles, then Run=0, timeout_err=1.
  - Then start with a responder present: program restarts from pc=0 and timeout_err clears.
- **End of memory.** Fill all 16 words with 0x1001; responder returns Done after 2 cycles.
  - Expect: instr_count=16, halted=1, pc=15; no wrap to 0.
- **Blocked inputs while busy.** Assert prog_we (addr 1, data 0xE000) and start during EXEC.
  - Expect: RAM[1] unchanged and execution continues uninterrupted.
- **Reset mid-operation and collisions.** Assert Rest mid-EXEC.
  - Expect: next edge Run=0, instruction=0x0000, all counters 0, state IDLE; RAM contents preserved (a rerun gives the same sequence).
  - Done arriving on the watchdog-expiry cycle → advance, no error.
